deal_n_cards: RTL
=================

// Module: deal_n_cards
// PURPOSE
//  Parametrised card-dealing controller; generalises the fixed 1/3/4-card dealers.
//  Per hand, it requests NUM cards from the shuffler/deck block over a next_card/card_valid handshake.
//  It packs the cards into one hand vector and publishes the vector atomically on completion.
//  Rejects duplicate and out-of-deck cards and re-requests them.
//  Times out a stalled deck and reports errors.
// PARAMETERS
//  MAX_CARDS  4    max cards per hand (1..8)
//  CARD_W     6    bits per card code
//  DECK_SIZE  52   valid codes are 0..DECK_SIZE-1; codes >= DECK_SIZE are rejected
//  DUP_CHECK  1    1 = reject a code already held in the current hand; 0 = accept all in-range codes
//  TIMEOUT    255  max cycles in REQ without card_valid before error; 0 = no timeout
// PORTS
//  clk             in   1                  clock, rising edge
//  rst             in   1                  asynchronous, active-low reset
//  deal_cards      in   1                  start request, sampled in IDLE only
//  num_cards       in   4                  cards for this hand, sampled with deal_cards
//  card            in   CARD_W             card code from deck, qualified by card_valid
//  card_valid      in   1                  deck holds it high until next_card drops
//  next_card       out  1                  request a card (Moore: high exactly while S==REQ)
//  players_cards   out  MAX_CARDS*CARD_W   hand; card k at [k*CARD_W +: CARD_W]
//  card_deal_done  out  1                  1-cycle pulse; players_cards updated this cycle
//  deal_error      out  1                  1-cycle pulse: bad num_cards or timeout
//  busy            out  1                  high in every state except IDLE
// BEHAVIOUR
//  Reset: S=IDLE; count, staging, timer = 0.
//   Outputs at reset: next_card=0, players_cards=0, card_deal_done=0, deal_error=0, busy=0.
//  States: IDLE, REQ, WAIT_LOW, DONE, ERR.
//  IDLE, deal_cards=1, 1<=num_cards<=MAX_CARDS:
//   latch num_cards; count=0; staging=0; timer=0; go REQ.
//  IDLE, deal_cards=1, num_cards==0 or >MAX_CARDS:
//   deal_error pulses next cycle; stay IDLE; players_cards unchanged.
//  deal_cards is ignored whenever S!=IDLE.
//  REQ: timer increments each cycle.
//   card_valid=1 and card accepted: staging slot[count]=card; count+1; timer=0; go WAIT_LOW.
//   card_valid=1 and card rejected: staging and count unchanged; timer=0; go WAIT_LOW.
//   card_valid=0 and TIMEOUT!=0 and timer==TIMEOUT-1: go ERR.
//  Reject rules:
//   card>=DECK_SIZE, or
//   DUP_CHECK=1 and card equals any staging slot j<count.
//   Compare only filled slots; zero-fill in unused slots never causes a false match on code 0.
//  WAIT_LOW:
//   count==latched num: go DONE immediately, without waiting for valid low.
//   Otherwise go REQ on the first cycle with card_valid=0.
//   Otherwise stay in WAIT_LOW; no timeout applies here.
//  DONE: players_cards<=staging; card_deal_done=1 for exactly this cycle; go IDLE.
//  ERR: deal_error=1 for one cycle; players_cards unchanged; go IDLE.
//  players_cards changes only on reset or in DONE; it holds the previous hand during a deal.
//  Slots >= num_cards are 0 in the published hand.
//  Latency for n cards with a zero-wait deck:
//   DONE pulse is 1 + n*3 - 1 cycles after the deal_cards sample.
//   The last card skips the valid-low wait.
//  Reset asserted mid-deal aborts the hand: no done or error pulse, hand cleared to 0.
// TESTING
//  1. MAX_CARDS=4; num=4; deck sends 10,20,30,40 -> done pulse once.
//     Expect players_cards={40,30,20,10}; next_card pulsed 4 times.
//  2. num=2; deck sends 5,5,7 (DUP_CHECK=1) -> second 5 re-requested; hand slot0=5, slot1=7, slots2-3=0.
//  3. num=1; deck sends 63 then 51 -> 63 rejected; hand slot0=51.
//     First card 0 of a hand is accepted (no false duplicate).
//  4. num=3; deck stops after 1 card; TIMEOUT=8 -> deal_error pulse 8 cycles into REQ.
//     Back to IDLE; previous hand unchanged.
//  5. num=0, and separately num=5 -> deal_error pulse, busy stays 0, no next_card.
//     deal_cards pulsed while busy -> ignored.
//  6. rst low in WAIT_LOW of card 2 -> all outputs 0 immediately.
//     Following deal of num=2 succeeds normally.

Source files
------------

// File: rtl/deal_n_cards.sv
// deal_n_cards: requests NUM cards from the deck, rejects bad/duplicate codes, publishes the hand atomically
module deal_n_cards #(
    parameter int MAX_CARDS = 4,
    parameter int CARD_W    = 6,
    parameter int DECK_SIZE = 52,
    parameter int DUP_CHECK = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        deal_cards,
    input  logic [3:0]                  num_cards,
    input  logic [CARD_W-1:0]           card,
    input  logic                        card_valid,
    output logic                        next_card,
    output logic [MAX_CARDS*CARD_W-1:0] players_cards,
    output logic                        card_deal_done,
    output logic                        deal_error,
    output logic                        busy
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_LOW, DONE, ERR} state_t;

    state_t                      state;
    logic [3:0]                  count;
    logic [3:0]                  num;
    logic [TW-1:0]               timer;
    logic [MAX_CARDS*CARD_W-1:0] staging;
    logic                        dup;
    logic                        reject;
    logic                        num_ok;

    // Card screening: out-of-deck codes and repeats of already-filled slots are refused
    always_comb begin
        dup = 1'b0;
        for (int j = 0; j < MAX_CARDS; j++)
            dup = dup | ((4'(j) < count) && (staging[j*CARD_W +: CARD_W] == card));
        reject = (32'(card) >= DECK_SIZE) || ((DUP_CHECK != 0) && dup);
        num_ok = (num_cards != 4'd0) && (32'(num_cards) <= MAX_CARDS);
    end

    // Deal FSM; every output is registered and set on entry to the state that owns it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            count          <= '0;
            num            <= '0;
            timer          <= '0;
            staging        <= '0;
            players_cards  <= '0;
            next_card      <= 1'b0;
            card_deal_done <= 1'b0;
            deal_error     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            card_deal_done <= 1'b0;
            deal_error     <= 1'b0;
            case (state)
                IDLE: begin
                    if (deal_cards && num_ok) begin
                        num       <= num_cards;
                        count     <= '0;
                        staging   <= '0;
                        timer     <= '0;
                        state     <= REQ;
                        next_card <= 1'b1;
                        busy      <= 1'b1;
                    end else if (deal_cards) begin
                        deal_error <= 1'b1;
                    end
                end
                REQ: begin
                    timer <= timer + 1'b1;
                    if (card_valid) begin
                        if (!reject) begin
                            for (int k = 0; k < MAX_CARDS; k++)
                                if (4'(k) == count) staging[k*CARD_W +: CARD_W] <= card;
                            count <= count + 4'd1;
                        end
                        timer     <= '0;
                        state     <= WAIT_LOW;
                        next_card <= 1'b0;
                    end else if ((TIMEOUT != 0) && (timer == T_LAST)) begin
                        state      <= ERR;
                        next_card  <= 1'b0;
                        deal_error <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (count == num) begin
                        state          <= DONE;
                        players_cards  <= staging;
                        card_deal_done <= 1'b1;
                    end else if (!card_valid) begin
                        state     <= REQ;
                        next_card <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
